// File: rtl/qpsk_sched_pkg.sv
// Shared definitions for the QPSK frame scheduler.
// Holds the scheduler state encoding, the default widths and the minimum
// divider value. There are no ports; every scheduler file imports this package.
package qpsk_sched_pkg;

  localparam int CNT_W   = 16;  // per-second CIC strobe counter width
  localparam int SYM_W   = 10;  // symbol count / index width
  localparam int GUARD_W = 8;   // guard interval width (CIC strobes)
  localparam int DIV_W   = 6;   // CIC strobes per symbol width

  // A programmed divider of 0 behaves as this value.
  localparam int DIV_MIN = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GUARD  = 2'd1,
    ST_ACTIVE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/qpsk_frame_scheduler_if.sv
// Bus interface between the timing front end / configuration source and the
// QPSK frame scheduler.
//   master : drives enable, cic_40_pulse, one_sec_pulse, cfg_*; observes outputs
//   slave  : the scheduler; consumes the inputs, drives sym_strobe, sym_index,
//            frame_active, frame_done, overrun, cic_pulse_counter
// Optional macro QPSK_SCHED_TIMESTAMP_EN adds frame_stamp and overrun_cnt.
interface qpsk_frame_scheduler_if #(
  parameter int CNT_W   = qpsk_sched_pkg::CNT_W,
  parameter int SYM_W   = qpsk_sched_pkg::SYM_W,
  parameter int GUARD_W = qpsk_sched_pkg::GUARD_W,
  parameter int DIV_W   = qpsk_sched_pkg::DIV_W
) ();

  logic               enable;
  logic               cic_40_pulse;
  logic               one_sec_pulse;
  logic [GUARD_W-1:0] cfg_guard;
  logic [DIV_W-1:0]   cfg_div;
  logic [SYM_W-1:0]   cfg_nsym;
  logic               sym_strobe;
  logic [SYM_W-1:0]   sym_index;
  logic               frame_active;
  logic               frame_done;
  logic               overrun;
  logic [CNT_W-1:0]   cic_pulse_counter;
`ifdef QPSK_SCHED_TIMESTAMP_EN
  logic [CNT_W-1:0]   frame_stamp;
  logic [7:0]         overrun_cnt;
`endif

  modport master (
    output enable, cic_40_pulse, one_sec_pulse, cfg_guard, cfg_div, cfg_nsym,
`ifdef QPSK_SCHED_TIMESTAMP_EN
    input  frame_stamp, overrun_cnt,
`endif
    input  sym_strobe, sym_index, frame_active, frame_done, overrun,
           cic_pulse_counter
  );

  modport slave (
    input  enable, cic_40_pulse, one_sec_pulse, cfg_guard, cfg_div, cfg_nsym,
`ifdef QPSK_SCHED_TIMESTAMP_EN
    output frame_stamp, overrun_cnt,
`endif
    output sym_strobe, sym_index, frame_active, frame_done, overrun,
           cic_pulse_counter
  );

endinterface

// File: rtl/qpsk_epoch_edge.sv
// Epoch edge detector and per-second CIC strobe counter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_enable     : edges are ignored and the counter is held at 0 while low
//   i_one_sec    : epoch marker (multi-cycle high); only its rising edge matters
//   i_cic        : one-cycle CIC decimator strobe
//   o_edge       : qualified epoch edge (combinational, same cycle as the rise)
//   o_cic_cnt    : CIC strobes since the last edge, saturating at all-ones
module qpsk_epoch_edge #(
  parameter int CNT_W = qpsk_sched_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_one_sec,
  input  logic             i_cic,
  output logic             o_edge,
  output logic [CNT_W-1:0] o_cic_cnt
);

  logic             r_one_sec_d;
  logic [CNT_W-1:0] r_cic_cnt;

  assign o_edge    = i_enable & i_one_sec & ~r_one_sec_d;
  assign o_cic_cnt = r_cic_cnt;

  // Delayed copy of the epoch marker; keeps tracking while disabled so a
  // marker already high when enable returns is not seen as a new epoch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_one_sec_d <= 1'b0;
    end else begin
      r_one_sec_d <= i_one_sec;
    end
  end

  // Strobe counter: restart on the edge (counting a coincident strobe), else
  // count up and stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cic_cnt <= {CNT_W{1'b0}};
    end else if (!i_enable) begin
      r_cic_cnt <= {CNT_W{1'b0}};
    end else if (o_edge) begin
      r_cic_cnt <= CNT_W'(i_cic);
    end else if (i_cic && !(&r_cic_cnt)) begin
      r_cic_cnt <= r_cic_cnt + CNT_W'(1);
    end else begin
      r_cic_cnt <= r_cic_cnt;
    end
  end

endmodule

// File: rtl/qpsk_frame_scheduler.sv
// QPSK frame scheduler: one symbol frame per one-second epoch. After each
// epoch edge it waits cfg_guard CIC strobes, then issues cfg_nsym symbol
// strobes, one every cfg_div CIC strobes (0 behaves as 1).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : qpsk_frame_scheduler_if.slave (inputs enable, cic_40_pulse,
//              one_sec_pulse, cfg_guard/div/nsym; outputs sym_strobe,
//              sym_index, frame_active, frame_done, overrun,
//              cic_pulse_counter)
// Optional macro QPSK_SCHED_TIMESTAMP_EN adds frame_stamp (counter value of
// each symbol's qualifying strobe) and overrun_cnt (saturating, rst only).
module qpsk_frame_scheduler #(
  parameter int CNT_W   = qpsk_sched_pkg::CNT_W,
  parameter int SYM_W   = qpsk_sched_pkg::SYM_W,
  parameter int GUARD_W = qpsk_sched_pkg::GUARD_W,
  parameter int DIV_W   = qpsk_sched_pkg::DIV_W
) (
  input  logic clk,
  input  logic rst,
  qpsk_frame_scheduler_if.slave bus
);

  import qpsk_sched_pkg::*;

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_GUARD  = ST_GUARD;
  localparam logic [1:0] S_ACTIVE = ST_ACTIVE;

  logic [1:0]         r_state;
  logic [GUARD_W-1:0] r_guard;
  logic [DIV_W-1:0]   r_div;
  logic [SYM_W-1:0]   r_nsym;
  logic [GUARD_W-1:0] r_gcnt;
  logic [DIV_W-1:0]   r_dcnt;
  logic [SYM_W-1:0]   r_scnt;
  logic               r_sym_strobe;
  logic [SYM_W-1:0]   r_sym_index;
  logic               r_frame_active;
  logic               r_frame_done;
  logic               r_overrun;

  logic               w_edge;
  logic [CNT_W-1:0]   w_cic_cnt;
  logic [DIV_W-1:0]   w_div_eff;
  logic               w_guard_done;
  logic               w_tick;
  logic               w_slot;
  logic               w_last;

  qpsk_epoch_edge #(.CNT_W(CNT_W)) u_epoch_edge (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (bus.enable),
    .i_one_sec (bus.one_sec_pulse),
    .i_cic     (bus.cic_40_pulse),
    .o_edge    (w_edge),
    .o_cic_cnt (w_cic_cnt)
  );

  assign w_div_eff = (bus.cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : bus.cfg_div;

  // The guard completes in the cycle gcnt reaches the latched guard; a CIC
  // strobe landing in that same cycle already counts toward the first symbol
  // so no strobe after the edge is ever lost.
  assign w_guard_done = (r_state == S_GUARD) && (r_gcnt == r_guard);
  assign w_tick       = bus.cic_40_pulse && ((r_state == S_ACTIVE) || w_guard_done);
  assign w_slot       = w_tick && (r_dcnt == (r_div - DIV_W'(1)));
  assign w_last       = w_slot && (r_scnt == (r_nsym - SYM_W'(1)));

  // Frame sequencer: epoch edges start (or abort and restart) a frame, the
  // guard counter then the divider/symbol counters pace the symbol strobes.
  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      r_state        <= S_IDLE;
      r_guard        <= {GUARD_W{1'b0}};
      r_div          <= {DIV_W{1'b0}};
      r_nsym         <= {SYM_W{1'b0}};
      r_gcnt         <= {GUARD_W{1'b0}};
      r_dcnt         <= {DIV_W{1'b0}};
      r_scnt         <= {SYM_W{1'b0}};
      r_sym_strobe   <= 1'b0;
      r_sym_index    <= {SYM_W{1'b0}};
      r_frame_active <= 1'b0;
      r_frame_done   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_sym_strobe <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      if (w_edge) begin
        r_overrun <= (r_state != S_IDLE);
        r_guard   <= bus.cfg_guard;
        r_div     <= w_div_eff;
        r_nsym    <= bus.cfg_nsym;
        r_gcnt    <= {GUARD_W{1'b0}};
        r_dcnt    <= {DIV_W{1'b0}};
        r_scnt    <= {SYM_W{1'b0}};
        if (bus.cfg_nsym == {SYM_W{1'b0}}) begin
          // Empty frame completes immediately without leaving IDLE.
          r_state        <= S_IDLE;
          r_frame_active <= 1'b0;
          r_frame_done   <= 1'b1;
        end else begin
          r_state        <= S_GUARD;
          r_frame_active <= 1'b1;
        end
      end else begin
        case (r_state)
          S_GUARD: begin
            if (w_guard_done) begin
              r_state <= S_ACTIVE;
            end else if (bus.cic_40_pulse) begin
              r_gcnt <= r_gcnt + GUARD_W'(1);
            end else begin
              r_gcnt <= r_gcnt;
            end
          end
          S_IDLE, S_ACTIVE: begin
          end
          default: begin
            r_state        <= S_IDLE;
            r_frame_active <= 1'b0;
          end
        endcase
        if (w_tick) begin
          if (w_slot) begin
            r_sym_strobe <= 1'b1;
            r_sym_index  <= r_scnt;
            r_dcnt       <= {DIV_W{1'b0}};
            r_scnt       <= r_scnt + SYM_W'(1);
            if (w_last) begin
              r_frame_done   <= 1'b1;
              r_frame_active <= 1'b0;
              r_state        <= S_IDLE;
            end else begin
              r_frame_active <= r_frame_active;
            end
          end else begin
            r_dcnt <= r_dcnt + DIV_W'(1);
          end
        end else begin
          r_dcnt <= r_dcnt;
        end
      end
    end
  end

  assign bus.sym_strobe        = r_sym_strobe;
  assign bus.sym_index         = r_sym_index;
  assign bus.frame_active      = r_frame_active;
  assign bus.frame_done        = r_frame_done;
  assign bus.overrun           = r_overrun;
  assign bus.cic_pulse_counter = w_cic_cnt;

`ifdef QPSK_SCHED_TIMESTAMP_EN
  logic [CNT_W-1:0] r_frame_stamp;
  logic [7:0]       r_overrun_cnt;

  // Symbol timestamp: counter value seen in each symbol's qualifying cycle.
  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      r_frame_stamp <= {CNT_W{1'b0}};
    end else if (!w_edge && w_slot) begin
      r_frame_stamp <= w_cic_cnt;
    end else begin
      r_frame_stamp <= r_frame_stamp;
    end
  end

  // Overrun tally survives enable drops; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun_cnt <= 8'd0;
    end else if (bus.enable && w_edge && (r_state != S_IDLE) && (r_overrun_cnt != 8'hFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 8'd1;
    end else begin
      r_overrun_cnt <= r_overrun_cnt;
    end
  end

  assign bus.frame_stamp = r_frame_stamp;
  assign bus.overrun_cnt = r_overrun_cnt;
`endif

endmodule

// File: tb/tb_qpsk_frame_scheduler.sv
// Self-checking bench for qpsk_frame_scheduler: a per-cycle reference model
// built from the frame rules (pulses counted since the epoch edge) feeds a
// scoreboard of expected pulses and per-cycle status; a monitor checks them.
module tb_qpsk_frame_scheduler;

  localparam int CNT_W = 16;
  localparam int SYM_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #40 clk = ~clk;

  qpsk_frame_scheduler_if bus ();

  qpsk_frame_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int cyc;
    bit strobe;
    int idx;
    bit done;
    bit ovr;
  } ev_t;

  typedef struct {
    bit active;
    int cnt;
    int idx;
  } st_t;

  ev_t evq[$];
  st_t stq[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit mon_on = 1'b0;

  // Reference model state
  bit m_osd;
  int m_cnt;
  bit m_busy;
  int m_pc;
  int m_g, m_d, m_n;
  int m_idx;
  bit m_active;

  always @(posedge clk) cyc <= cyc + 1;

  // Apply one cycle of inputs, predict the response after the next edge.
  task automatic step(input bit cic, input bit osp);
    ev_t e;
    st_t s;
    bit  edge_s;
    bus.cic_40_pulse  = cic;
    bus.one_sec_pulse = osp;
    e.cyc = cyc + 1; e.strobe = 1'b0; e.idx = 0; e.done = 1'b0; e.ovr = 1'b0;
    if (rst) begin
      m_osd = 1'b0; m_cnt = 0; m_busy = 1'b0; m_pc = 0; m_idx = 0; m_active = 1'b0;
    end else if (!bus.enable) begin
      m_osd = osp; m_cnt = 0; m_busy = 1'b0; m_pc = 0; m_idx = 0; m_active = 1'b0;
    end else begin
      edge_s = osp && !m_osd;
      m_osd  = osp;
      if (edge_s) m_cnt = cic ? 1 : 0;
      else if (cic && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (edge_s) begin
        e.ovr = m_busy;
        m_g  = int'(bus.cfg_guard);
        m_d  = (bus.cfg_div == 6'd0) ? 1 : int'(bus.cfg_div);
        m_n  = int'(bus.cfg_nsym);
        m_pc = 0;
        if (m_n == 0) begin
          e.done = 1'b1; m_busy = 1'b0; m_active = 1'b0;
        end else begin
          m_busy = 1'b1; m_active = 1'b1;
        end
      end else if (m_busy && cic) begin
        m_pc = m_pc + 1;
        if (m_pc > m_g && ((m_pc - m_g) % m_d) == 0) begin
          e.strobe = 1'b1;
          m_idx = (m_pc - m_g) / m_d - 1;
          if (m_idx == m_n - 1) begin
            e.done = 1'b1; m_busy = 1'b0; m_active = 1'b0;
          end
        end
      end
    end
    e.idx = m_idx;
    if (e.strobe || e.done || e.ovr) evq.push_back(e);
    s.active = m_active; s.cnt = m_cnt; s.idx = m_idx;
    stq.push_back(s);
    @(posedge clk);
    #1;
  endtask

  // Periodic CIC strobes and a periodic epoch marker.
  task automatic run_seg(input int ncyc, input int per, input int phase,
                         input int ep_len, input int hi_len, input bit cic_all);
    for (int i = 0; i < ncyc; i++) begin
      step(cic_all || (((i + phase) % per) == 0), (i % ep_len) < hi_len);
    end
  endtask

  task automatic set_cfg(input int g, input int d, input int n);
    bus.cfg_guard = 8'(g);
    bus.cfg_div   = 6'(d);
    bus.cfg_nsym  = 10'(n);
  endtask

  ev_t me;
  st_t ms;

  // Monitor: per-cycle status plus pulse scoreboard.
  always @(negedge clk) begin
    if (mon_on) begin
      if (stq.size() > 0) begin
        ms = stq.pop_front();
        n_chk++;
        if (bus.frame_active === ms.active && bus.cic_pulse_counter === CNT_W'(ms.cnt) &&
            bus.sym_index === SYM_W'(ms.idx)) begin
          n_pass++;
        end else begin
          $display("FAIL status cyc=%0d: got active=%0b cnt=%0d idx=%0d, expected active=%0b cnt=%0d idx=%0d",
                   cyc, bus.frame_active, bus.cic_pulse_counter, bus.sym_index,
                   ms.active, ms.cnt, ms.idx);
        end
      end
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        me = evq.pop_front();
        n_chk++;
        $display("FAIL missed_pulse at cyc=%0d: got nothing, expected strobe=%0b idx=%0d done=%0b ovr=%0b",
                 me.cyc, me.strobe, me.idx, me.done, me.ovr);
      end
      if (bus.sym_strobe === 1'b1 || bus.frame_done === 1'b1 || bus.overrun === 1'b1) begin
        n_chk++;
        if (evq.size() == 0 || evq[0].cyc != cyc) begin
          $display("FAIL unexpected_pulse cyc=%0d: got strobe=%0b done=%0b ovr=%0b, expected none",
                   cyc, bus.sym_strobe, bus.frame_done, bus.overrun);
        end else begin
          me = evq.pop_front();
          if (bus.sym_strobe === me.strobe && bus.frame_done === me.done &&
              bus.overrun === me.ovr && bus.sym_index === SYM_W'(me.idx)) begin
            n_pass++;
          end else begin
            $display("FAIL pulse cyc=%0d: got strobe=%0b idx=%0d done=%0b ovr=%0b, expected strobe=%0b idx=%0d done=%0b ovr=%0b",
                     cyc, bus.sym_strobe, bus.sym_index, bus.frame_done, bus.overrun,
                     me.strobe, me.idx, me.done, me.ovr);
          end
        end
      end
    end
  end

  initial begin
    int per, ph, ep, hi;
    bus.enable = 1'b1;
    bus.cic_40_pulse = 1'b0;
    bus.one_sec_pulse = 1'b0;
    set_cfg(0, 1, 1);
    mon_on = 1'b1;

    // Reset state
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);

    // Directed epochs; every edge coincides with a CIC strobe
    set_cfg(2, 4, 5);    run_seg(600, 8, 0, 600, 20, 1'b0);
    set_cfg(0, 1, 3);    run_seg(600, 8, 0, 600, 20, 1'b0);
    set_cfg(0, 3, 0);    run_seg(600, 8, 0, 600, 20, 1'b0);
    set_cfg(10, 8, 100); run_seg(600, 8, 0, 600, 20, 1'b0);
    set_cfg(10, 8, 100); run_seg(600, 8, 0, 600, 20, 1'b0);
    set_cfg(1, 0, 2);    run_seg(600, 8, 0, 600, 20, 1'b0);

    // Reset then enable drop mid-frame, then a clean frame
    set_cfg(1, 2, 50);   run_seg(300, 8, 0, 600, 20, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    rst = 1'b0;
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) step((i % 2) == 0, 1'b0);
    bus.enable = 1'b1;
    set_cfg(3, 2, 4);    run_seg(600, 8, 3, 600, 20, 1'b0);

    // Randomised epochs
    for (int k = 0; k < 20; k++) begin
      per = $urandom_range(1, 10);
      ph  = $urandom_range(0, 9);
      ep  = $urandom_range(150, 500);
      hi  = $urandom_range(1, 100);
      if ($urandom_range(0, 7) == 0) set_cfg($urandom_range(0, 15), $urandom_range(0, 6), 200);
      else set_cfg($urandom_range(0, 15), $urandom_range(0, 6), $urandom_range(0, 25));
      if ($urandom_range(0, 5) == 0) begin
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) step($urandom_range(0, 1) == 1, 1'b0);
        bus.enable = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
      end
      run_seg(ep, per, ph, ep, hi, 1'b0);
    end

    // Saturation: CIC strobe every clock, no epoch edge
    set_cfg(0, 1, 2);
    run_seg(70000, 1, 0, 100000, 0, 1'b1);
    run_seg(200, 4, 0, 200, 10, 1'b0);

    step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    n_chk++;
    if (evq.size() == 0 && stq.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pulses and %0d status entries left, expected 0 and 0",
                  evq.size(), stq.size());
    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/qpsk_frame_scheduler.md
Name: qpsk_frame_scheduler

Overview:
- Sequences one QPSK symbol frame per one-second epoch.
- On each rising edge of one_sec_pulse it waits a programmable guard interval measured in CIC-40 decimator strobes. It then issues a programmed number of symbol strobes, one every cfg_div CIC strobes.
- Sits between the timing front end (cic_40_pulse, one_sec_pulse sources) and the QPSK modulator/demodulator symbol datapath, which consumes sym_strobe and sym_index.

Parameters:
- CNT_W, 16, width of the per-second CIC strobe counter.
- SYM_W, 10, width of the symbol count and symbol index.
- GUARD_W, 8, width of the guard interval in CIC strobes.
- DIV_W, 6, width of the CIC-strobes-per-symbol divider.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scheduler enable. Low forces IDLE synchronously.
- cic_40_pulse  in  1  one-cycle strobe from the CIC decimator.
- one_sec_pulse  in  1  epoch marker, multi-cycle high. Only its rising edge is used.
- cfg_guard  in  GUARD_W  guard interval in CIC strobes.
- cfg_div  in  DIV_W  CIC strobes per symbol. 0 is treated as 1.
- cfg_nsym  in  SYM_W  symbols per frame.
- sym_strobe  out  1  one-cycle symbol-slot strobe.
- sym_index  out  SYM_W  index of the current or last strobed symbol.
- frame_active  out  1  high from frame start until frame end.
- frame_done  out  1  one-cycle pulse when a frame completes normally.
- overrun  out  1  one-cycle pulse when an epoch edge aborts an unfinished frame.
- cic_pulse_counter  out  CNT_W  CIC strobes counted since the last epoch edge.

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0, edge-detect register 0.
- Epoch edge definition: `edge = one_sec_pulse & ~one_sec_d`, where `one_sec_d` is one_sec_pulse registered. The FSM acts on edge in the same cycle; effects are visible on the next clock.
- States: IDLE, GUARD, ACTIVE.
- IDLE:
  - On edge (with enable high): latch cfg_guard, cfg_div, cfg_nsym.
  - Clear the guard, divider and index counters.
  - Assert frame_active. Go to GUARD.
  - If latched nsym == 0: do not enter GUARD. Pulse frame_done next cycle, remain IDLE, frame_active stays 0.
- GUARD:
  - Each cic_40_pulse increments gcnt.
  - When gcnt == latched guard, go to ACTIVE. With guard == 0 this happens on the cycle after the edge.
- ACTIVE:
  - Each cic_40_pulse increments dcnt.
  - On a pulse with dcnt == div-1: assert sym_strobe next cycle with sym_index = current scnt, clear dcnt, increment scnt.
  - The first strobe is at index 0.
  - After the strobe with index nsym-1: pulse frame_done together with that strobe, clear frame_active, go to IDLE.
- Registered outputs: sym_strobe and frame_done are registered, with latency 1 clk from the qualifying cic_40_pulse. sym_index holds its value between strobes.
- Edge while in GUARD or ACTIVE:
  - Abort the frame and pulse overrun for 1 cycle; no frame_done.
  - Re-latch cfg and restart GUARD with counters cleared. frame_active stays high.
- cic_pulse_counter:
  - Edge loads 0, or 1 if cic_40_pulse coincides with the edge.
  - Otherwise +1 per cic_40_pulse, saturating at all-ones.
  - Runs in every state while enable is high.
- enable low: the next cycle forces IDLE and clears frame_active and all counters; pulses are suppressed. Edges are ignored while enable is low.
- A cic_40_pulse coincident with the edge is not counted toward guard (it is counted in cic_pulse_counter).
- Reset asserted mid-frame: identical to the reset values above on the next clock.

Optional Feature:
- Macro QPSK_SCHED_TIMESTAMP_EN.
- When defined:
  - Extra output frame_stamp [CNT_W-1:0].
  - On each sym_strobe, frame_stamp latches the cic_pulse_counter value of the qualifying cycle.
  - Extra output overrun_cnt [7:0]: saturating count of overruns, cleared only by rst.
- When undefined: neither port nor its logic exists. Behaviour is otherwise identical.

Decomposition:
- Package qpsk_sched_pkg holds:
  - the state enum (IDLE, GUARD, ACTIVE);
  - default widths CNT_W/SYM_W/GUARD_W/DIV_W;
  - helper constant DIV_MIN = 1.
- One natural sub-module: qpsk_epoch_edge. It registers one_sec_pulse and produces the edge strobe plus cic_pulse_counter (load/increment/saturate), instantiated once.

Test Plan (clk 80 ns, cic_40_pulse every 320 clk, one_sec_pulse high 165 clk every 16500 clk):
- guard=2, div=4, nsym=5 -> first sym_strobe 1 clk after the 6th CIC strobe past the edge; indices 0..4 every 1280 clk; frame_done with index 4; frame_active low afterwards.
- guard=0, div=1, nsym=3 -> strobes on the 1st, 2nd, 3rd CIC strobes after the edge; frame_done on the 3rd.
- guard=10, div=8, nsym=100 (exceeds epoch) -> overrun pulse 1 clk after the next edge; no frame_done; GUARD restarts; sym_index restarts at 0.
- nsym=0 -> frame_done 1 clk after the edge; no sym_strobe; frame_active never high.
- Edge coincident with a cic_40_pulse -> cic_pulse_counter reads 1 next cycle; saturation check with CIC strobes every clk for 70000 clk -> holds 0xFFFF.
- rst asserted then enable dropped mid-ACTIVE -> all outputs 0 next clk; the next edge starts a clean frame.
